// File: rtl/star_tally.sv
// Star collection tally: detects each star's first touch once per level, tracks
// count and saturating score, drives a flash window and a level-complete flag.
module star_tally #(
  parameter int N_STARS         = 5,
  parameter int CNT_W           = 4,
  parameter int POINTS_PER_STAR = 10,
  parameter int SCORE_MAX       = 999,
  parameter int FLASH_CYCLES    = 25000000
) (
  input  logic               sys_clk,
  input  logic               RST,
  input  logic [N_STARS-1:0] touch_star,
  input  logic               level_restart,
  output logic [CNT_W-1:0]   star_count,
  output logic [9:0]         score,
  output logic [N_STARS-1:0] collected_mask,
  output logic               collect_pulse,
  output logic [2:0]         collect_idx,
  output logic               flash,
  output logic               all_collected
);

  localparam int TMR_W = $clog2(FLASH_CYCLES);

  typedef enum logic [1:0] {
    ST_PLAY,
    ST_FLASH,
    ST_DONE
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [N_STARS-1:0] r_prev;
  logic [N_STARS-1:0] r_mask;
  logic [CNT_W-1:0]   r_count;
  logic [9:0]         r_score;
  logic               r_pulse;
  logic [2:0]         r_idx;
  logic               r_flash;
  logic [TMR_W-1:0]   r_timer;

  logic [N_STARS-1:0] w_new_hits;
  logic [3:0]         w_hit_cnt;
  logic [2:0]         w_low_idx;
  logic [CNT_W-1:0]   w_count_next;
  logic [31:0]        w_score_sum;
  logic [9:0]         w_score_next;
  logic               w_accept;
  logic               w_complete;

  // A star counts only on a fresh rise and only if it has not been counted this level.
  assign w_new_hits = touch_star & ~r_prev & ~r_mask;

  // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    w_hit_cnt = '0;
    w_low_idx = '0;
    for (int i = N_STARS - 1; i >= 0; i--) begin
      if (w_new_hits[i]) begin
        w_hit_cnt = w_hit_cnt + 4'd1;
        w_low_idx = 3'(i);
      end
    end
  end

  assign w_accept     = (r_state != ST_DONE) && (|w_new_hits) && !level_restart;
  assign w_count_next = r_count + CNT_W'(w_hit_cnt);
  assign w_complete   = (w_count_next == CNT_W'(N_STARS));
  assign w_score_sum  = 32'(r_score) + 32'(POINTS_PER_STAR) * 32'(w_hit_cnt);
  assign w_score_next = (w_score_sum > 32'(SCORE_MAX)) ? 10'(SCORE_MAX) : w_score_sum[9:0];

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge sys_clk or posedge RST) begin
    if (RST) r_state <= ST_PLAY;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    if (level_restart) begin
      w_next_state = ST_PLAY;
    end else if (w_accept) begin
      w_next_state = w_complete ? ST_DONE : ST_FLASH;
    end else if (r_state == ST_FLASH && r_timer == '0) begin
      w_next_state = ST_PLAY;
    end
  end

  // Restart clears the level tally but keeps the cumulative score.
  always_ff @(posedge sys_clk or posedge RST) begin
    if (RST) begin
      r_prev  <= '0;
      r_mask  <= '0;
      r_count <= '0;
      r_score <= '0;
      r_pulse <= 1'b0;
      r_idx   <= '0;
      r_flash <= 1'b0;
      r_timer <= '0;
    end else begin
      r_prev  <= touch_star;
      r_pulse <= w_accept;
      if (level_restart) begin
        r_mask  <= '0;
        r_count <= '0;
        r_flash <= 1'b0;
        r_timer <= '0;
      end else if (w_accept) begin
        r_mask  <= r_mask | w_new_hits;
        r_count <= w_count_next;
        r_score <= w_score_next;
        r_idx   <= w_low_idx;
        r_flash <= 1'b1;
        r_timer <= TMR_W'(FLASH_CYCLES - 1);
      end else if (r_flash) begin
        if (r_timer == '0) r_flash <= 1'b0;
        else               r_timer <= r_timer - TMR_W'(1);
      end
    end
  end

  always_comb begin
    star_count     = r_count;
    score          = r_score;
    collected_mask = r_mask;
    collect_pulse  = r_pulse;
    collect_idx    = r_idx;
    flash          = r_flash;
    all_collected  = (r_state == ST_DONE);
  end

endmodule
